// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words
// and writes DEPTH of them from address 0. Optional IMEM_LOADER_CHECKSUM_EN adds a running sum of written words.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam logic [31:0] LAST_WA = 32'(4 * (DEPTH - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] wa_q, wa_d;
    logic [31:0] wd_q, wd_d;

    // Outputs are pure decodes of registered state, so no input reaches an output combinationally.
    assign in_ready = (state_q == ST_RECV);
    assign we       = (state_q == ST_WRITE);
    assign busy     = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign done     = (state_q == ST_DONE);
    assign wa       = wa_q;
    assign wd       = wd_q;

    // Next-state logic: byte assembly, write sequencing and address advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RECV;
                    wa_d    = 32'd0;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (in_valid) begin
                    case (cnt_q)
                        2'd0:    wd_d[7:0]   = in_data;
                        2'd1:    wd_d[15:8]  = in_data;
                        2'd2:    wd_d[23:16] = in_data;
                        2'd3:    wd_d[31:24] = in_data;
                        default: wd_d        = wd_q;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                // The last word leaves wa parked on its address rather than wrapping.
                if (wa_q == LAST_WA) begin
                    state_d = ST_DONE;
                end else begin
                    wa_d    = wa_q + 32'd4;
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            wa_q    <= 32'd0;
            wd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    assign checksum = csum_q;

    // Running checksum: cleared on an accepted start, accumulates each written word.
    always_comb begin
        csum_d = csum_q;
        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
            csum_d = 32'd0;
        end else if (state_q == ST_WRITE) begin
            csum_d = csum_q + wd_q;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= 32'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: a DEPTH=2 instance for the
// functional scenarios and a DEPTH=64 instance for the full-load boundary.
module tb_imem_loader;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        sel;
    logic        start2, start64;

    logic        rdy2, we2, busy2, done2;
    logic [31:0] wa2, wd2;
    logic        rdy64, we64, busy64, done64;
    logic [31:0] wa64, wd64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cs2, cs64;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] q2_wa[$];
    logic [31:0] q2_wd[$];
    int          n64     = 0;
    int          bad64   = 0;
    logic [31:0] last64_wa = 32'd0;
    logic [31:0] last64_wd = 32'd0;

    imem_loader #(.DEPTH(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2),
        .we(we2), .wa(wa2), .wd(wd2), .busy(busy2), .done(done2)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cs2)
`endif
    );

    imem_loader #(.DEPTH(64)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy64),
        .we(we64), .wa(wa64), .wd(wd64), .busy(busy64), .done(done64)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cs64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (we2) begin
            q2_wa.push_back(wa2);
            q2_wd.push_back(wd2);
        end
        if (we64) begin
            n64++;
            last64_wa = wa64;
            last64_wd = wd64;
            if (wa64 > 32'h0000_00FC) bad64++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        q2_wa.delete();
        q2_wd.delete();
        @(negedge clk);
        if (sel) start64 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start2  = 1'b0;
        start64 = 1'b0;
    endtask

    // Present a byte and return on the falling edge before the accepting rising edge.
    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!(sel ? rdy64 : rdy2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(sel ? done64 : done2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_reached", {31'd0, (sel ? done64 : done2)}, 32'd1);
    endtask

    initial begin
        logic [7:0] v1 [8];
        v1 = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h02, 8'h55, 8'h00};
        reset_n  = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        sel      = 1'b0;
        start2   = 1'b0;
        start64  = 1'b0;

        // Reset values, forced asynchronously
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst_in_ready", {31'd0, rdy2}, 32'd0);
        check_eq("rst_we", {31'd0, we2}, 32'd0);
        check_eq("rst_wa", wa2, 32'd0);
        check_eq("rst_wd", wd2, 32'd0);
        check_eq("rst_busy", {31'd0, busy2}, 32'd0);
        check_eq("rst_done", {31'd0, done2}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_no_autoload", {31'd0, busy2}, 32'd0);

        // Two-word load, continuous stream
        do_start();
        check_eq("start_busy", {31'd0, busy2}, 32'd1);
        check_eq("start_ready", {31'd0, rdy2}, 32'd1);
        for (int i = 0; i < 8; i++) push(v1[i]);
        drop_valid();
        wait_done();
        check_eq("t1_nwrites", q2_wa.size(), 32'd2);
        check_eq("t1_wa0", q2_wa[0], 32'h0000_0000);
        check_eq("t1_wd0", q2_wd[0], 32'h0000_0513);
        check_eq("t1_wa1", q2_wa[1], 32'h0000_0004);
        check_eq("t1_wd1", q2_wd[1], 32'h0055_02B3);
        check_eq("t1_busy", {31'd0, busy2}, 32'd0);
        check_eq("t1_ready", {31'd0, rdy2}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("t1_checksum", cs2, 32'h0055_07C6);
`endif

        // Restart from DONE
        do_start();
        check_eq("restart_done", {31'd0, done2}, 32'd0);
        check_eq("restart_busy", {31'd0, busy2}, 32'd1);
        check_eq("restart_ready", {31'd0, rdy2}, 32'd1);
        check_eq("restart_wa", wa2, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("restart_checksum", cs2, 32'd0);
`endif

        // Three bytes, then a 7-cycle stall containing an ignored start
        push(8'h11);
        push(8'h22);
        push(8'h33);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start2   = (i == 2);
        end
        check_eq("stall_wa", wa2, 32'd0);
        check_eq("stall_partial", {8'd0, wd2[23:0]}, 32'h0033_2211);
        check_eq("stall_ready", {31'd0, rdy2}, 32'd1);
        check_eq("stall_no_write", q2_wa.size(), 32'd0);
        push(8'h44);
        check_eq("lat_we_before", {31'd0, we2}, 32'd0);
        @(negedge clk);
        check_eq("lat_we_next", {31'd0, we2}, 32'd1);
        check_eq("lat_wd", wd2, 32'h4433_2211);
        check_eq("lat_wa", wa2, 32'd0);
        push(8'hAA);
        check_eq("we_one_cycle", {31'd0, we2}, 32'd0);
        push(8'hBB);
        push(8'hCC);
        push(8'hDD);
        drop_valid();
        wait_done();
        check_eq("t3_nwrites", q2_wa.size(), 32'd2);
        check_eq("t3_wd1", q2_wd[1], 32'hDDCC_BBAA);
        check_eq("t3_wa1", q2_wa[1], 32'h0000_0004);

        // Reset during the WRITE cycle of word 1
        do_start();
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_we", {31'd0, we2}, 32'd0);
        check_eq("mid_rst_wa", wa2, 32'd0);
        check_eq("mid_rst_wd", wd2, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy2}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done2}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, rdy2}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("mid_rst_checksum", cs2, 32'd0);
`endif
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_rst_idle", {31'd0, busy2}, 32'd0);
        check_eq("post_rst_nwrites", q2_wa.size(), 32'd1);
        do_start();
        for (int i = 1; i <= 8; i++) push(8'(i));
        drop_valid();
        wait_done();
        check_eq("reload_nwrites", q2_wa.size(), 32'd2);
        check_eq("reload_wa0", q2_wa[0], 32'd0);
        check_eq("reload_wd0", q2_wd[0], 32'h0403_0201);
        check_eq("reload_wd1", q2_wd[1], 32'h0807_0605);

        // Full 64-word load
        sel = 1'b1;
        do_start();
        for (int i = 0; i < 256; i++) push(8'(i));
        drop_valid();
        wait_done();
        repeat (3) @(negedge clk);
        check_eq("d64_nwrites", n64, 32'd64);
        check_eq("d64_last_wa", last64_wa, 32'h0000_00FC);
        check_eq("d64_last_wd", last64_wd, 32'hFFFE_FDFC);
        check_eq("d64_no_overrun", bad64, 32'd0);
        check_eq("d64_wa_hold", wa64, 32'h0000_00FC);
        check_eq("d64_done", {31'd0, done64}, 32'd1);
        check_eq("d2_undisturbed", {31'd0, done2}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction words written per load.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse; begins a load from word address 0.
REQ-005 in_data  input  8  instruction byte stream, little-endian within each word.
REQ-006 in_valid  input  1  in_data holds a valid byte.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 we  output  1  instruction-memory write enable, one cycle per word.
REQ-009 wa  output  32  instruction-memory byte address, word-aligned.
REQ-010 wd  output  32  instruction-memory write data.
REQ-011 busy  output  1  load in progress (RECV or WRITE).
REQ-012 done  output  1  all DEPTH words written; held until the next start.

Function
REQ-013 The loader SHALL implement the FSM states IDLE, RECV, WRITE and DONE.
REQ-014 IDLE/DONE: start=1 -> RECV; wa<=0; byte count<=0; done<=0.
REQ-015 RECV: in_ready SHALL be 1; in IDLE, WRITE and DONE, in_ready SHALL be 0.
REQ-016 A byte SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-017 Byte k of a word (k=0..3) SHALL be placed in wd bits [8k+7:8k].
REQ-018 Acceptance of byte 3 SHALL move the FSM to WRITE on the same edge.
REQ-019 In WRITE, we SHALL be 1 for exactly one cycle, with wa and wd stable for that cycle.
REQ-020 Latency: the byte-3 acceptance edge at cycle N SHALL give we=1 during cycle N+1.
REQ-021 Leaving WRITE with wa=4*(DEPTH-1) SHALL go to DONE; otherwise wa<=wa+4 and the FSM returns to RECV.
REQ-022 Wrap-around: wa SHALL never exceed 4*(DEPTH-1) and SHALL never be written past it.
REQ-023 start SHALL be ignored in RECV and WRITE.
REQ-024 Any in_valid stall of arbitrary length in RECV SHALL preserve the partial word and byte count.
REQ-025 busy SHALL be 1 exactly in RECV and WRITE.
REQ-026 done SHALL be 1 exactly in DONE.
REQ-027 All outputs SHALL be driven from registers or decoded from state only, with no combinational path from inputs.
REQ-028 Minimum throughput SHALL be one word per 5 cycles (4 accept cycles + 1 write cycle).

Reset
REQ-029 reset_n=0 SHALL immediately force the following, independent of clk: state=IDLE, in_ready=0, we=0, wa=0, wd=0, busy=0, done=0, byte count=0.
REQ-030 Reset asserted mid-load (including during WRITE) SHALL abort the load with no further we pulse.
REQ-031 After reset deasserts, a new start SHALL be required to load.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN: when defined, the loader SHALL add output checksum (32 bits), equal to the mod-2^32 sum of all wd values written since the last start.
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined, checksum SHALL be cleared on start and on reset, and SHALL update on the edge ending each WRITE cycle.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 DEPTH=2; start; stream bytes 13,05,00,00,B3,02,55,00 continuously -> we pulses with wa=0 wd=00000513, then wa=4 wd=005502B3; done=1; with IMEM_LOADER_CHECKSUM_EN, checksum=005507C6.
REQ-036 DEPTH=64; stream 256 bytes -> exactly 64 we pulses, last at wa=000000FC; done=1; no write at 00000100.
REQ-037 in_valid deasserted for 7 cycles after byte 2 -> byte 3 completes the word unchanged; we occurs 1 cycle after byte 3 is accepted.
REQ-038 start pulsed during RECV after 2 bytes -> ignored; wa and the partial word are unchanged.
REQ-039 reset_n pulled low in the WRITE cycle of word 1 -> we=0 immediately; all outputs are at reset values; a subsequent start reloads from wa=0.
REQ-040 start in DONE -> done=0, busy=1, in_ready=1 on the next cycle; the load repeats from wa=0.
